ndp_operand_loader: RTL and testbench

- Parametrised input front-end for NDP_core.
- Accepts the packed host operand stream: per reduction step k, one A column followed by one B row, several elements per bus word.
- Unpacks each step into one parallel A-column vector and one B-row vector, handed to the systolic array over a valid/ready handshake.
- Generalises the fixed 32-bit, 16-bit-element, fixed-depth load sequence to:
  - configurable bus width, element width, array dimensions and runtime depth k_len;
  - input and output backpressure;
  - length error reporting.

---
 rtl/ndp_operand_loader_if.sv | 27 ++
 rtl/ndp_operand_loader.sv | 102 ++++++++++
 tb/tb_ndp_operand_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ndp_operand_loader_if.sv
// ndp_operand_loader_if: packed operand input stream and unpacked vector output stream of the operand loader.
// Ports: in_valid/in_data/in_ready carry host bus words; vec_valid/vec_ready/vec_a/vec_b/vec_k/vec_last carry one unpacked step.
interface ndp_operand_loader_if #(
  parameter int WIDTH     = 16,
  parameter int BUS_WIDTH = 32,
  parameter int A_ROWS    = 4,
  parameter int B_COLS    = 4,
  parameter int KW        = 5
);
  logic                     in_valid;
  logic [BUS_WIDTH-1:0]     in_data;
  logic                     in_ready;
  logic                     vec_valid;
  logic                     vec_ready;
  logic [A_ROWS*WIDTH-1:0]  vec_a;
  logic [B_COLS*WIDTH-1:0]  vec_b;
  logic [KW-1:0]            vec_k;
  logic                     vec_last;
  modport slave (
    input  in_valid, in_data, vec_ready,
    output in_ready, vec_valid, vec_a, vec_b, vec_k, vec_last
  );
  modport master (
    output in_valid, in_data, vec_ready,
    input  in_ready, vec_valid, vec_a, vec_b, vec_k, vec_last
  );
endinterface

// File: rtl/ndp_operand_loader.sv
// ndp_operand_loader: unpacks the packed A-column/B-row host stream into one parallel vector pair per reduction step.
// Ports: clk, reset (sync, active-high); start/k_len launch a job; busy, done (pulse after last vector), err_len (pulse on bad k_len);
// io (slave modport) carries the input word stream and the output vector stream.
module ndp_operand_loader #(
  parameter int WIDTH     = 16,
  parameter int BUS_WIDTH = 32,
  parameter int A_ROWS    = 4,
  parameter int B_COLS    = 4,
  parameter int MAX_K     = 16,
  parameter int KW        = $clog2(MAX_K + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  ndp_operand_loader_if.slave io
);
  localparam int EPW  = BUS_WIDTH / WIDTH;
  localparam int WA   = A_ROWS / EPW;
  localparam int WB   = B_COLS / EPW;
  localparam int WMAX = WA > WB ? WA : WB;
  localparam int CW   = $clog2(WMAX + 1);

  if (BUS_WIDTH % WIDTH != 0) begin : g_bad_bus
    $error("BUS_WIDTH must be a multiple of WIDTH");
  end
  if (A_ROWS % EPW != 0 || B_COLS % EPW != 0) begin : g_bad_dims
    $error("A_ROWS and B_COLS must be multiples of BUS_WIDTH/WIDTH");
  end

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, EMIT} state_t;

  state_t                  state, state_n;
  logic [KW-1:0]           k_len_q, k_q;
  logic [CW-1:0]           wcnt;
  logic [A_ROWS*WIDTH-1:0] a_q;
  logic [B_COLS*WIDTH-1:0] b_q;
  logic                    k_ok, acc, last, fire;

  assign k_ok = k_len != '0 && k_len <= KW'(MAX_K);
  assign acc  = io.in_valid && io.in_ready;
  assign last = k_q == k_len_q - KW'(1);
  assign fire = state == EMIT && io.vec_ready;
  assign busy = state != IDLE;
  assign io.vec_a = a_q;
  assign io.vec_b = b_q;
  assign io.vec_k = k_q;

  always_comb begin
    state_n      = state;
    io.in_ready  = 1'b0;
    io.vec_valid = 1'b0;
    io.vec_last  = 1'b0;
    unique case (state)
      IDLE:   state_n = start && k_ok ? LOAD_A : IDLE;
      LOAD_A: begin
        io.in_ready = 1'b1;
        state_n     = acc && wcnt == CW'(WA - 1) ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        io.in_ready = 1'b1;
        state_n     = acc && wcnt == CW'(WB - 1) ? EMIT : LOAD_B;
      end
      EMIT: begin
        io.vec_valid = 1'b1;
        io.vec_last  = last;
        state_n      = io.vec_ready ? (last ? IDLE : LOAD_A) : EMIT;
      end
      default: state_n = IDLE;
    endcase
  end

  // Lanes of a word are contiguous in the packed vector, so word w lands at bit w*BUS_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k_len_q <= '0;
      k_q     <= '0;
      wcnt    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done    <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state   <= state_n;
      done    <= fire && last;
      err_len <= state == IDLE && start && !k_ok;
      if (state == IDLE && start && k_ok) begin
        k_len_q <= k_len;
        k_q     <= '0;
        wcnt    <= '0;
      end
      if (acc) wcnt <= state_n != state ? '0 : wcnt + CW'(1);
      if (acc && state == LOAD_A) a_q[wcnt*BUS_WIDTH +: BUS_WIDTH] <= io.in_data;
      if (acc && state == LOAD_B) b_q[wcnt*BUS_WIDTH +: BUS_WIDTH] <= io.in_data;
      if (fire && !last) k_q <= k_q + KW'(1);
    end
  end
endmodule

// File: tb/tb_ndp_operand_loader.sv
// tb_ndp_operand_loader: scoreboard bench for the operand loader at default and 64-bit-bus parameters.
module tb_ndp_operand_loader;
  typedef struct {
    logic [127:0] a;
    logic [63:0]  b;
    logic [4:0]   k;
    logic         last;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [4:0] klen0 = '0, klen1 = '0;
  logic       busy0, done0, err0, busy1, done1, err1;

  ndp_operand_loader_if #(.WIDTH(16), .BUS_WIDTH(32), .A_ROWS(4), .B_COLS(4), .KW(5)) if0();
  ndp_operand_loader_if #(.WIDTH(16), .BUS_WIDTH(64), .A_ROWS(8), .B_COLS(4), .KW(5)) if1();

  ndp_operand_loader #(.WIDTH(16), .BUS_WIDTH(32), .A_ROWS(4), .B_COLS(4), .MAX_K(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .k_len(klen0),
    .busy(busy0), .done(done0), .err_len(err0), .io(if0)
  );
  ndp_operand_loader #(.WIDTH(16), .BUS_WIDTH(64), .A_ROWS(8), .B_COLS(4), .MAX_K(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .k_len(klen1),
    .busy(busy1), .done(done1), .err_len(err1), .io(if1)
  );

  vec_t q0[$], q1[$];
  int checks = 0, passes = 0;
  int cyc = 0, acc_cnt = 0, first_cyc = 0, exp_lat = 0, stall_n = 0, stall_cnt = 0;
  int ndone0 = 0, nvec1 = 0;
  logic pend0 = 1'b0, pend1 = 1'b0, prev_valid = 1'b0, have_hold = 1'b0;
  logic [63:0] hold_a, hold_b;
  logic [4:0]  hold_k;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic timeout(input string nm);
    checks++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [127:0] vecv(input int n, input int k, input int stride, input int base);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v[i*16 +: 16] = 16'(base + stride*k + i);
    return v;
  endfunction

  task automatic word0(input logic [31:0] d);
    int n = 0;
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    do begin @(negedge clk); n++; end while (!if0.in_ready && n < 100);
    if (!if0.in_ready) timeout("word0");
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic word1(input logic [63:0] d);
    int n = 0;
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    do begin @(negedge clk); n++; end while (!if1.in_ready && n < 100);
    if (!if1.in_ready) timeout("word1");
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic go0(input logic [4:0] kl);
    @(posedge clk); #1;
    start0 = 1'b1; klen0 = kl;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic job0(input int kl, input bit gap);
    logic [127:0] va, vb;
    go0(5'(kl));
    for (int k = 0; k < kl; k++) begin
      va = vecv(4, k, 4, 'h0100);
      vb = vecv(4, k, 4, 'h0200);
      q0.push_back('{va, vb[63:0], 5'(k), k == kl - 1});
      for (int w = 0; w < 4; w++) begin
        word0(w < 2 ? va[w*32 +: 32] : vb[(w-2)*32 +: 32]);
        if (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic idle0();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy0 || q0.size() != 0) && n < 500);
    if (n >= 500) timeout("idle0");
    @(negedge clk);
  endtask

  initial begin
    if0.vec_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (if0.vec_valid && stall_cnt < stall_n) begin
        if0.vec_ready = 1'b0;
        stall_cnt++;
      end else begin
        if0.vec_ready = if0.vec_valid || stall_n == 0;
        if (!if0.vec_valid) stall_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (reset) begin
      acc_cnt = 0; pend0 = 1'b0; have_hold = 1'b0; prev_valid = 1'b0;
    end else begin
      if (done0) ndone0++;
      if (pend0) begin
        chk("done0", done0, 1);
        chk("busy_at_done0", busy0, 0);
        pend0 = 1'b0;
      end else if (done0) timeout("spurious_done0");
      if (if0.in_valid && if0.in_ready) begin
        if (acc_cnt % 4 == 0) first_cyc = cyc;
        acc_cnt++;
      end
      if (if0.vec_valid && !prev_valid && exp_lat > 0) chk("latency0", 128'(cyc - first_cyc), 128'(exp_lat));
      prev_valid = if0.vec_valid;
      if (if0.vec_valid) chk("in_ready_emit0", if0.in_ready, 0);
      if (if0.vec_valid && have_hold) begin
        chk("stable_a0", if0.vec_a, hold_a);
        chk("stable_b0", if0.vec_b, hold_b);
        chk("stable_k0", if0.vec_k, hold_k);
      end
      if (if0.vec_valid && !if0.vec_ready) begin
        have_hold = 1'b1; hold_a = if0.vec_a; hold_b = if0.vec_b; hold_k = if0.vec_k;
      end
      if (if0.vec_valid && if0.vec_ready) begin
        have_hold = 1'b0;
        if (q0.size() == 0) timeout("unexpected_vec0");
        else begin
          e = q0.pop_front();
          chk("vec_a0", if0.vec_a, e.a);
          chk("vec_b0", if0.vec_b, e.b);
          chk("vec_k0", if0.vec_k, e.k);
          chk("vec_last0", if0.vec_last, e.last);
          if (e.k == 1) begin
            chk("step1_a0", if0.vec_a, 64'h0107_0106_0105_0104);
            chk("step1_b0", if0.vec_b, 64'h0207_0206_0205_0204);
          end
          pend0 = e.last;
        end
      end
    end
  end

  always @(negedge clk) begin
    vec_t e;
    if (!reset) begin
      if (err1) timeout("err_len1_during_job");
      if (pend1) begin
        chk("done1", done1, 1);
        pend1 = 1'b0;
      end
      if (if1.vec_valid && if1.vec_ready) begin
        nvec1++;
        if (q1.size() == 0) timeout("unexpected_vec1");
        else begin
          e = q1.pop_front();
          chk("vec_a1", if1.vec_a, e.a);
          chk("vec_b1", if1.vec_b, e.b);
          chk("vec_k1", if1.vec_k, e.k);
          chk("vec_last1", if1.vec_last, e.last);
          if (e.k == 0) chk("step0_a1", if1.vec_a, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
          pend1 = e.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] va, vb;
    int n;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.vec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_vec_valid", if0.vec_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_vec_a", if0.vec_a, 0);
    chk("rst_vec_k", if0.vec_k, 0);

    exp_lat = 4;
    job0(3, 0);
    idle0();

    stall_n = 4;
    job0(3, 0);
    idle0();
    stall_n = 0;

    exp_lat = 7;
    job0(3, 1);
    idle0();
    exp_lat = 0;

    go0(5'd0);
    @(negedge clk);
    chk("err_len_k0", err0, 1);
    chk("busy_k0", busy0, 0);
    chk("in_ready_k0", if0.in_ready, 0);
    @(negedge clk);
    chk("err_len_k0_pulse", err0, 0);
    go0(5'd17);
    @(negedge clk);
    chk("err_len_k17", err0, 1);
    chk("busy_k17", busy0, 0);
    chk("in_ready_k17", if0.in_ready, 0);
    @(negedge clk);
    chk("err_len_k17_pulse", err0, 0);

    go0(5'd2);
    va = vecv(4, 0, 4, 'h0100);
    vb = vecv(4, 0, 4, 'h0200);
    word0(va[31:0]);
    word0(va[63:32]);
    word0(vb[31:0]);
    reset = 1'b1; start0 = 1'b1; klen0 = 5'd1;
    @(posedge clk); #1;
    reset = 1'b0; start0 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy0, 0);
    chk("midrst_vec_valid", if0.vec_valid, 0);
    chk("midrst_vec_a", if0.vec_a, 0);
    chk("midrst_vec_b", if0.vec_b, 0);
    chk("midrst_done", done0, 0);
    job0(1, 0);
    idle0();
    chk("ndone0", 128'(ndone0), 128'd4);

    @(posedge clk); #1;
    start1 = 1'b1; klen1 = 5'd16;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      va = vecv(8, k, 16, 'h0100);
      vb = vecv(4, k, 16, 'h0200);
      q1.push_back('{va, vb[63:0], 5'(k), k == 15});
      if (k == 5) begin start1 = 1'b1; klen1 = 5'd3; end
      word1(va[63:0]);
      start1 = 1'b0;
      word1(va[127:64]);
      word1(vb[63:0]);
    end
    n = 0;
    do begin @(negedge clk); n++; end while ((busy1 || q1.size() != 0) && n < 500);
    if (n >= 500) timeout("idle1");
    @(negedge clk);
    @(negedge clk);
    chk("nvec1", 128'(nvec1), 128'd16);
    chk("busy1_end", busy1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
